// File: rtl/dot_acc_pl_pkg.sv
// Shared types and default widths for the dot-product row accumulator.
// Purely declarative: no logic, no latency, no flow control.
package dot_acc_pl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    PUSH = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo_dq.sv
// Small synchronous FIFO. Writes and pops are visible one edge after they occur, and the read port shows registered storage.
// A write is dropped when the FIFO is full and a pop is dropped when it is empty. A pop does not free a slot for a write in the same cycle.
module sync_fifo_dq #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dot_acc_pl.sv
// Sums row_len partials into one row result and queues it. The FIFO is written 2 edges after the last partial.
// Upstream flow control uses stall. Results are drained by the valid/ack handshake, and the FSM holds in PUSH while the FIFO is full.
module dot_acc_pl
  import dot_acc_pl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [DATA_WIDTH-1:0] in_res,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  busy,
  output logic                  stall,
  output logic                  err
);

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   STALL_LVL = CW'(FIFO_DEPTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic [DATA_WIDTH-1:0] res_q;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  last_part;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_cnt;

  assign acc_sum   = acc + in_res;
  assign last_part = (cnt == len_q - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = (row_len == '0) ? PUSH : ACC;
      ACC:  if (in_ready && last_part) state_nxt = PUSH;
      PUSH: begin
        // Full is taken from the registered count, so a same-cycle pop cannot make room.
        if (!fifo_full) begin
          fifo_push = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      res_q <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_q <= row_len;
          acc   <= '0;
          cnt   <= '0;
          if (row_len == '0) res_q <= '0;
        end
        ACC: if (in_ready) begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
          if (last_part) res_q <= acc_sum;
        end
        default: ;
      endcase
      // Partials outside an open row are dropped and remembered until reset.
      if (in_ready && state != ACC) err <= 1'b1;
    end
  end

  sync_fifo_dq #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (out_ack),
    .wr_data (res_q),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state != IDLE);
  assign stall     = (state == PUSH) || (fifo_cnt >= STALL_LVL);

endmodule
